ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, then shifts one byte out on the
// keyboard-generated clock and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    n_q, n_d, nm1;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          kdo_q, kdo_d;
  logic          aerr_q, aerr_d;
  logic          done_q, done_d, ack_err_q, ack_err_d, to_err_q, to_err_d;
  logic [2:0]    kc_q, kd_q;
  logic          fall;

  // Sync chain resets high (idle bus) so release from reset cannot look like a fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kc_q <= 3'b111;
      kd_q <= 3'b111;
    end else begin
      kc_q <= {kc_q[1:0], kclk_in};
      kd_q <= {kd_q[1:0], kdata_in};
    end
  end

  assign fall = !kc_q[1] && kc_q[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      inh_q     <= '0;
      to_q      <= '0;
      n_q       <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      kdo_q     <= 1'b0;
      aerr_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      n_q       <= n_d;
      data_q    <= data_d;
      par_q     <= par_d;
      kdo_q     <= kdo_d;
      aerr_q    <= aerr_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      to_err_q  <= to_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    to_d      = to_q;
    n_d       = n_q;
    nm1       = 4'd0;
    data_d    = data_q;
    par_d     = par_q;
    kdo_d     = kdo_q;
    aerr_d    = aerr_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    to_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        kdo_d = 1'b0;
        inh_d = '0;
        to_d  = '0;
        n_d   = '0;
        if (tx_valid) begin
          data_d  = tx_data;
          par_d   = ~^tx_data;
          aerr_d  = 1'b0;
          kdo_d   = (INHIBIT_CYCLES == 1);
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_d = S_REQ;
          to_d    = '0;
          n_d     = '0;
          kdo_d   = 1'b1;
        end else begin
          inh_d = inh_q + 1'b1;
          if (inh_d == INH_LAST) kdo_d = 1'b1;
        end
      end
      default: begin
        // Timeout has priority over any edge seen in the same cycle.
        if (to_q == TO_LAST) begin
          state_d  = S_IDLE;
          kdo_d    = 1'b0;
          to_err_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
          if (state_q == S_WAIT) begin
            if (kc_q[1] && kd_q[1]) begin
              state_d = S_IDLE;
              done_d  = !aerr_q;
            end
          end else if (fall) begin
            n_d = (n_q == 4'd11) ? n_q : n_q + 4'd1;
            if (state_q == S_ACK) begin
              state_d = S_WAIT;
              kdo_d   = 1'b0;
              if (kd_q[1]) begin
                ack_err_d = 1'b1;
                aerr_d    = 1'b1;
              end
            end else begin
              state_d = (n_d == 4'd10) ? S_ACK : S_SEND;
              nm1     = n_d - 4'd1;
              if (n_d >= 4'd1 && n_d <= 4'd8) kdo_d = ~data_q[nm1[2:0]];
              else if (n_d == 4'd9)          kdo_d = ~par_q;
              else                           kdo_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = !tx_ready;
  assign kclk_oe     = (state_q == S_INHIBIT);
  assign kdata_oe    = kdo_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = to_err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model clocks frames out of the DUT and
// checks decoded frames against a scoreboard of expected frames.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 3000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, kclk_oe, kdata_oe, busy, done, ack_err, timeout_err;
  logic       m_clk = 1'b1, m_data = 1'b1;
  logic       kclk_in, kdata_in;

  // Open-drain bus: either side can pull low.
  assign kclk_in  = m_clk & ~kclk_oe;
  assign kdata_in = m_data & ~kdata_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .kclk_in(kclk_in), .kdata_in(kdata_in), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_done = 0, n_aerr = 0, n_to = 0;
  logic [10:0] sb[$];

  always @(negedge clk) begin
    if (done)        n_done++;
    if (ack_err)     n_aerr++;
    if (timeout_err) n_to++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    int c;
    logic kd_last;
    @(negedge clk);
    chk("ready_before", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    c = 0;
    kd_last = 1'b0;
    while (kclk_oe && c < 200) begin
      c++;
      kd_last = kdata_oe;
      @(negedge clk);
    end
    chk("inhibit_len", c, INH);
    chk("start_bit_last_inhibit", kd_last, 1);
    chk("req_kdata_oe", kdata_oe, 1);
  endtask

  task automatic frame(input logic [7:0] b, input bit ack_hi, input bit inject, input int rst_at);
    logic [10:0] got, exp;
    int d0, a0, t0, c;
    d0 = n_done; a0 = n_aerr; t0 = n_to;
    got = '0;
    if (rst_at == 0) sb.push_back({1'b1, ~^b, b, 1'b0});
    start_tx(b);
    ticks(30);
    got[0] = kdata_in;
    for (int k = 1; k <= 10; k++) begin
      m_clk = 1'b0;
      if (inject && k == 3) begin
        ticks(5);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("ready_in_send", tx_ready, 0);
        tx_valid = 1'b0;
        ticks(HALF - 6);
      end else if (rst_at == k) begin
        ticks(10);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_oe", {kclk_oe, kdata_oe}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", tx_ready, 1);
        rst   = 1'b1;
        m_clk = 1'b1;
        ticks(100);
        return;
      end else begin
        ticks(HALF);
      end
      got[k] = kdata_in;
      m_clk  = 1'b1;
      ticks(HALF);
    end
    m_data = ack_hi;
    ticks(20);
    m_clk = 1'b0;
    ticks(HALF);
    m_clk = 1'b1;
    ticks(10);
    m_data = 1'b1;
    c = 0;
    while (busy && c < 100) begin
      c++;
      @(negedge clk);
    end
    chk("idle_reached", busy, 0);
    chk("ready_after", tx_ready, 1);
    ticks(5);
    chk("done_pulses", n_done - d0, ack_hi ? 0 : 1);
    chk("ackerr_pulses", n_aerr - a0, ack_hi ? 1 : 0);
    chk("no_timeout", n_to - t0, 0);
    chk("oe_released", {kclk_oe, kdata_oe}, 0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      exp = sb.pop_front();
      chk("frame_bits", got, exp);
    end
  endtask

  task automatic timeout_case(input logic [7:0] b);
    int d0, t0, c;
    d0 = n_done; t0 = n_to;
    start_tx(b);
    c = 0;
    while (!timeout_err && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_cycle", c, TO);
    chk("timeout_oe", {kclk_oe, kdata_oe}, 0);
    chk("timeout_busy", busy, 0);
    ticks(3);
    chk("timeout_pulses", n_to - t0, 1);
    chk("timeout_no_done", n_done - d0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ticks(3);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oe", {kclk_oe, kdata_oe}, 0);
    chk("rst_pulses", {done, ack_err, timeout_err}, 0);
    rst = 1'b1;
    ticks(5);

    frame(8'hED, 1'b0, 1'b0, 0);
    frame(8'h01, 1'b0, 1'b0, 0);
    frame(8'hFF, 1'b0, 1'b0, 0);
    frame(8'h3C, 1'b1, 1'b0, 0);
    timeout_case(8'h12);
    ticks(10);
    frame(8'h96, 1'b0, 1'b0, 4);
    frame(8'h55, 1'b0, 1'b0, 0);
    frame(8'h5A, 1'b0, 1'b1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
